cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
Two-port arbiter that shares one `cache` instance between an instruction-fetch requester (port A) and a data requester (port B).
- Each port presents the same enable/address/data/write_enable/busy/data_out_ready handshake that the cache itself exposes, so a requester cannot tell it is shared.
- Sits between the core and `cache`; the cache keeps sole ownership of the SDRAM controller interface.
- Round-robin by default; optional fixed priority for A, with a starvation limit.

Parameters:
FixedPriorityA, 0, 1 = A wins ties (subject to StarveLimit); 0 = round-robin.
StarveLimit, 4, consecutive A grants while B waits before B is forced; range 1..15.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
{a,b}_enable  input  1  port requests a transaction
{a,b}_address  input  32  byte address
{a,b}_write_enable  input  4  byte-lane write mask; 0 = read
{a,b}_data_in  input  32  write data
{a,b}_data_out  output  32  read data; always equals cache_data_out
{a,b}_data_out_ready  output  1  read data valid for this port
{a,b}_busy  output  1  port must hold its request stable
cache_enable  output  1  to cache enable
cache_address  output  32  latched winner address
cache_write_enable  output  4  latched winner mask
cache_data_in  output  32  latched winner data
cache_data_out  input  32  from cache
cache_data_out_ready  input  1  from cache
cache_busy  input  1  from cache

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; cache_enable = 0; cache_address / cache_write_enable / cache_data_in = 0.
  - {a,b}_data_out_ready = 0; {a,b}_busy = 1.
  - last_grant = B, so A wins the first round-robin tie.
  - starve_cnt = 0.
- State machine IDLE -> ISSUE -> (WAIT) -> IDLE.
- IDLE:
  - {a,b}_busy = 0 for a port not requesting; a requesting port sees busy = 1.
  - If any enable is high and cache_busy = 0, pick a winner, latch its address/write_enable/data_in into req regs, set owner, go to ISSUE.
  - If cache_busy = 1, stay in IDLE; nothing is latched.
- Arbitration:
  - Only one port enabled: that port wins.
  - Both enabled, round-robin: the port that is not last_grant wins.
  - Both enabled, FixedPriorityA = 1: A wins unless starve_cnt = StarveLimit, in which case B wins.
  - starve_cnt increments on each A grant while b_enable = 1, saturates at StarveLimit, and clears on any B grant.
- ISSUE (exactly one cycle):
  - cache_enable = 1; cache_* driven from the req regs.
  - Write with cache_busy = 0: complete this cycle, go to IDLE.
  - Otherwise go to WAIT.
- WAIT:
  - cache_enable stays 1 with the req regs held.
  - A read completes in the first cycle with cache_data_out_ready = 1 and cache_busy = 0.
  - A write completes in the first cycle with cache_busy = 0.
- Completion cycle:
  - owner_busy = 0.
  - owner_data_out_ready = 1 for reads only.
  - last_grant <= owner; next state IDLE.
  - The non-owner port keeps busy = 1 throughout.
- Latency:
  - Minimum 2 cycles from enable to completion for a write hit.
  - Minimum 3 cycles for a read hit.
  - There is one IDLE bubble between back-to-back transactions.
- Request stability:
  - Requester changes to address/data/enable after the grant are ignored; the req regs are used.
  - If the owner drops enable mid-transaction, the transaction still completes, and the completion pulse is still generated.
- data_out_ready of the non-owner port is always 0, even if cache_data_out_ready is high.
- Reset mid-transaction: immediate return to IDLE with the reset values; the in-flight cache access is abandoned. The cache has its own reset.
- No timeout: WAIT persists while the cache is busy (SDRAM miss/eviction).

Decomposition:
- cache_arbiter_pkg:
  - state_t enum {IDLE, ISSUE, WAIT}.
  - port_t enum {PORT_A, PORT_B}.
  - req_t packed struct {address[31:0], write_enable[3:0], data_in[31:0]}.
  - StarveCntWidth = 4.
- One combinational sub-module, arb_pick, computes the winner from:
  - {a,b}_enable
  - last_grant
  - starve_cnt
  - FixedPriorityA and StarveLimit
- All sequencing stays in cache_arbiter.
- Target implementation size: about 180 lines.

Test Plan:
1. Bench setup: SDRAM_Controller_HS_Top, mt48lc2m32b2 and cache (LineIndexBitWidth 1, RamAddressBitWidth 8). Wait for O_sdrc_init_done before stimulus.
2. A writes 0x1234_5678 to addr 4, then A reads addr 4 -> a_data_out = 0x1234_5678 with a_data_out_ready = 1; b_busy = 0 and b_data_out_ready = 0 throughout.
3. A and B both request in the same cycle after reset (round-robin); A reads 4, B writes 0xabcd_ef01 to 8 -> A is served first, then B after one IDLE bubble. A subsequent B read of 8 returns 0xabcd_ef01.
4. B writes 0xabcd_ef01 to addr 70 (forces a line eviction), while A immediately reads addr 4 -> A stays busy for the whole B WAIT period; A then gets 0x1234_5678.
5. FixedPriorityA = 1, StarveLimit = 2; A and B request continuously -> grant order A, A, B, A, A, B.
6. Assert rst during WAIT of an A read miss -> within the same cycle cache_enable = 0 and a_busy = b_busy = 1. After rst is released, a fresh A read of 4 completes correctly.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the two-port cache arbiter.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  write_enable;
    logic [31:0] data_in;
  } req_t;

  localparam int StarveCntWidth = 4;

  // A request with any byte lane enabled is a write.
  function automatic logic req_is_write(input req_t r);
    return |r.write_enable;
  endfunction

endpackage

// File: rtl/cache_arbiter_arb_pick.sv
// Combinational winner selection between port A and port B.
// Round-robin against last_grant, or fixed priority for A with a
// starvation escape that hands the slot to B once starve_cnt saturates.
module cache_arbiter_arb_pick
  import cache_arbiter_pkg::*;
#(
  parameter bit FixedPriorityA = 1'b0,
  parameter int StarveLimit    = 4
) (
  input  logic                      a_enable,
  input  logic                      b_enable,
  input  port_t                     last_grant,
  input  logic [StarveCntWidth-1:0] starve_cnt,
  output port_t                     winner
);

  localparam logic [StarveCntWidth-1:0] StarveMax = StarveCntWidth'(StarveLimit);

  // Pick the winner; the result is only used when at least one port requests
  always_comb begin
    winner = PORT_A;
    if (a_enable && b_enable) begin
      if (FixedPriorityA) begin
        winner = (starve_cnt == StarveMax) ? PORT_B : PORT_A;
      end else begin
        winner = (last_grant == PORT_A) ? PORT_B : PORT_A;
      end
    end else if (b_enable) begin
      winner = PORT_B;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache between an instruction-fetch port (A) and a data
// port (B). Each port sees the cache's own enable/busy/data_out_ready
// handshake. The winner's request is latched at grant time, so the
// requester may change its inputs afterwards without effect.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter bit FixedPriorityA = 1'b0,
  parameter int StarveLimit    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_enable,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_write_enable,
  input  logic [31:0] a_data_in,
  output logic [31:0] a_data_out,
  output logic        a_data_out_ready,
  output logic        a_busy,
  input  logic        b_enable,
  input  logic [31:0] b_address,
  input  logic [3:0]  b_write_enable,
  input  logic [31:0] b_data_in,
  output logic [31:0] b_data_out,
  output logic        b_data_out_ready,
  output logic        b_busy,
  output logic        cache_enable,
  output logic [31:0] cache_address,
  output logic [3:0]  cache_write_enable,
  output logic [31:0] cache_data_in,
  input  logic [31:0] cache_data_out,
  input  logic        cache_data_out_ready,
  input  logic        cache_busy
);

  localparam logic [StarveCntWidth-1:0] StarveMax = StarveCntWidth'(StarveLimit);

  state_t                    state_reg;
  port_t                     owner_reg;
  port_t                     last_grant_reg;
  req_t                      req_reg;
  logic [StarveCntWidth-1:0] starve_cnt_reg;

  port_t winner;
  req_t  req_next;
  logic  any_req;
  logic  req_write;
  logic  complete;

  cache_arbiter_arb_pick #(
    .FixedPriorityA(FixedPriorityA),
    .StarveLimit   (StarveLimit)
  ) u_arb_pick (
    .a_enable  (a_enable),
    .b_enable  (b_enable),
    .last_grant(last_grant_reg),
    .starve_cnt(starve_cnt_reg),
    .winner    (winner)
  );

  assign any_req   = a_enable | b_enable;
  assign req_write = req_is_write(req_reg);
  assign req_next  = (winner == PORT_A)
                   ? '{address: a_address, write_enable: a_write_enable, data_in: a_data_in}
                   : '{address: b_address, write_enable: b_write_enable, data_in: b_data_in};

  // Completion: a write finishes on the first non-busy cycle (ISSUE or
  // WAIT); a read only from WAIT, once the cache returns data.
  always_comb begin
    complete = 1'b0;
    case (state_reg)
      ISSUE:   complete = req_write & ~cache_busy;
      WAIT:    complete = ~cache_busy & (req_write | cache_data_out_ready);
      default: complete = 1'b0;
    endcase
  end

  // Grant, issue and wait sequencing with starvation bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= PORT_A;
      last_grant_reg <= PORT_B;
      req_reg        <= '0;
      starve_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req && !cache_busy) begin
            req_reg   <= req_next;
            owner_reg <= winner;
            state_reg <= ISSUE;
            if (winner == PORT_B) begin
              starve_cnt_reg <= '0;
            end else if (b_enable && (starve_cnt_reg != StarveMax)) begin
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
          end
        end
        ISSUE, WAIT: begin
          if (complete) begin
            last_grant_reg <= owner_reg;
            state_reg      <= IDLE;
          end else begin
            state_reg <= WAIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cache_enable       = (state_reg == ISSUE) || (state_reg == WAIT);
  assign cache_address      = req_reg.address;
  assign cache_write_enable = req_reg.write_enable;
  assign cache_data_in      = req_reg.data_in;
  assign a_data_out         = cache_data_out;
  assign b_data_out         = cache_data_out;

  // Port handshake: during reset both ports are held busy; otherwise a
  // port that requests is busy until its own completion cycle, and an
  // idle port sees busy = 0.
  always_comb begin
    a_busy           = 1'b1;
    b_busy           = 1'b1;
    a_data_out_ready = 1'b0;
    b_data_out_ready = 1'b0;
    if (!rst) begin
      a_busy = a_enable;
      b_busy = b_enable;
      if (complete) begin
        if (owner_reg == PORT_A) begin
          a_busy           = 1'b0;
          a_data_out_ready = ~req_write;
        end else begin
          b_busy           = 1'b0;
          b_data_out_ready = ~req_write;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter. Instance 0 is round-robin, instance 1
// uses fixed A priority with a starvation limit of 2. Each instance has a
// small behavioural cache: addresses below 64 hit, others take MissLat
// extra cycles with busy raised from the issue cycle onward.
module tb_cache_arbiter;

  localparam int MissLat = 4;

  typedef struct packed {
    logic inst;
    logic port;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  logic        a_en  [2];
  logic [31:0] a_adr [2];
  logic [3:0]  a_we  [2];
  logic [31:0] a_din [2];
  logic [31:0] a_dout[2];
  logic        a_rdy [2];
  logic        a_busy[2];
  logic        b_en  [2];
  logic [31:0] b_adr [2];
  logic [3:0]  b_we  [2];
  logic [31:0] b_din [2];
  logic [31:0] b_dout[2];
  logic        b_rdy [2];
  logic        b_busy[2];
  logic        c_en  [2];
  logic [31:0] c_adr [2];
  logic [3:0]  c_we  [2];
  logic [31:0] c_din [2];
  logic [31:0] c_dout[2];
  logic        c_rdy [2];
  logic        c_busy[2];

  int   n_cmp = 0;
  int   n_err = 0;
  int   b_viol = 0;
  logic watch_b = 1'b0;
  ev_t  log_q[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic [31:0] mem [64];
    logic        en_q, busy_q, rdy_q, is_rd;
    logic [5:0]  idx;
    logic [31:0] wd, dout_q;
    int          cnt;
    int          stray_cnt = 0;
    logic        start, miss;

    cache_arbiter #(
      .FixedPriorityA(gi == 1),
      .StarveLimit   ((gi == 1) ? 2 : 4)
    ) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .a_enable            (a_en[gi]),
      .a_address           (a_adr[gi]),
      .a_write_enable      (a_we[gi]),
      .a_data_in           (a_din[gi]),
      .a_data_out          (a_dout[gi]),
      .a_data_out_ready    (a_rdy[gi]),
      .a_busy              (a_busy[gi]),
      .b_enable            (b_en[gi]),
      .b_address           (b_adr[gi]),
      .b_write_enable      (b_we[gi]),
      .b_data_in           (b_din[gi]),
      .b_data_out          (b_dout[gi]),
      .b_data_out_ready    (b_rdy[gi]),
      .b_busy              (b_busy[gi]),
      .cache_enable        (c_en[gi]),
      .cache_address       (c_adr[gi]),
      .cache_write_enable  (c_we[gi]),
      .cache_data_in       (c_din[gi]),
      .cache_data_out      (c_dout[gi]),
      .cache_data_out_ready(c_rdy[gi]),
      .cache_busy          (c_busy[gi])
    );

    assign start      = c_en[gi] && !en_q;
    assign miss       = start && (c_adr[gi][31:6] != 26'd0);
    assign c_busy[gi] = busy_q | miss;
    assign c_rdy[gi]  = rdy_q;
    assign c_dout[gi] = dout_q;

    // Behavioural cache: a new access starts on the rising edge of enable
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        en_q   <= 1'b0;
        busy_q <= 1'b0;
        rdy_q  <= 1'b0;
        is_rd  <= 1'b0;
        idx    <= '0;
        wd     <= '0;
        dout_q <= '0;
        cnt    <= 0;
      end else begin
        en_q  <= c_en[gi];
        rdy_q <= 1'b0;
        if (miss) begin
          busy_q <= 1'b1;
          cnt    <= MissLat;
          idx    <= c_adr[gi][7:2];
          wd     <= c_din[gi];
          is_rd  <= (c_we[gi] == 4'd0);
        end else if (start) begin
          if (c_we[gi] != 4'd0) begin
            mem[c_adr[gi][7:2]] <= c_din[gi];
          end else begin
            dout_q <= mem[c_adr[gi][7:2]];
            rdy_q  <= 1'b1;
          end
        end else if (busy_q) begin
          cnt <= cnt - 1;
          if (cnt == 1) begin
            busy_q <= 1'b0;
            if (is_rd) begin
              dout_q <= mem[idx];
              rdy_q  <= 1'b1;
            end else begin
              mem[idx] <= wd;
            end
          end
        end
      end
    end

    // Log each completion seen by a requester and count ready-while-busy
    always @(negedge clk) begin
      if (!rst) begin
        if (a_en[gi] && !a_busy[gi]) log_q.push_back('{inst: gi[0], port: 1'b0});
        if (b_en[gi] && !b_busy[gi]) log_q.push_back('{inst: gi[0], port: 1'b1});
        if ((a_rdy[gi] && a_busy[gi]) || (b_rdy[gi] && b_busy[gi])) stray_cnt <= stray_cnt + 1;
      end
    end
  end

  // Port B of instance 0 must stay idle-looking while only A is active
  always @(negedge clk) begin
    if (!rst && watch_b && (b_busy[0] || b_rdy[0])) b_viol <= b_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input int p, input logic en, input logic [3:0] we,
                         input logic [31:0] adr, input logic [31:0] din);
    if (p == 0) begin
      a_en[k] = en; a_we[k] = we; a_adr[k] = adr; a_din[k] = din;
    end else begin
      b_en[k] = en; b_we[k] = we; b_adr[k] = adr; b_din[k] = din;
    end
  endtask

  // Single transaction; lat counts cycles from request to completion inclusive
  task automatic run_one(input int k, input int p, input logic [3:0] we, input logic [31:0] adr,
                         input logic [31:0] din, output logic rdy, output logic [31:0] dout,
                         output int lat);
    logic done;
    done = 1'b0; rdy = 1'b0; dout = '0; lat = 0;
    set_req(k, p, 1'b1, we, adr, din);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (p == 0 && !a_busy[k]) begin done = 1'b1; rdy = a_rdy[k]; dout = a_dout[k]; lat = c; end
      if (p == 1 && !b_busy[k]) begin done = 1'b1; rdy = b_rdy[k]; dout = b_dout[k]; lat = c; end
    end
    @(posedge clk); #1;
    set_req(k, p, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("single_done", {31'd0, done}, 32'd1);
  endtask

  // B requests at once, A after a_delay cycles; each drops on completion
  task automatic run_two(input int k, input int a_delay,
                         input logic [3:0] wea, input logic [31:0] adra, input logic [31:0] dina,
                         input logic [3:0] web, input logic [31:0] adrb, input logic [31:0] dinb,
                         output int cyc_a, output int cyc_b, output logic [31:0] dout_a);
    cyc_a = 0; cyc_b = 0; dout_a = '0;
    set_req(k, 1, 1'b1, web, adrb, dinb);
    if (a_delay == 0) set_req(k, 0, 1'b1, wea, adra, dina);
    for (int c = 1; c <= 60 && (cyc_a == 0 || cyc_b == 0); c++) begin
      @(negedge clk);
      if (cyc_a == 0 && a_en[k] && !a_busy[k]) begin cyc_a = c; dout_a = a_dout[k]; end
      if (cyc_b == 0 && b_en[k] && !b_busy[k]) cyc_b = c;
      @(posedge clk); #1;
      if (cyc_a != 0) set_req(k, 0, 1'b0, 4'd0, 32'd0, 32'd0);
      if (cyc_b != 0) set_req(k, 1, 1'b0, 4'd0, 32'd0, 32'd0);
      if (c == a_delay) set_req(k, 0, 1'b1, wea, adra, dina);
    end
  endtask

  initial begin
    logic        rdy;
    logic [31:0] dout;
    int          lat, cyc_a, cyc_b;
    logic        got;
    logic [5:0]  exp_order;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(k, 1, 1'b0, 4'd0, 32'd0, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    chk("rst_cache_enable", {31'd0, c_en[0]}, 32'd0);
    chk("rst_cache_address", c_adr[0], 32'd0);
    chk("rst_cache_we", {28'd0, c_we[0]}, 32'd0);
    chk("rst_cache_din", c_din[0], 32'd0);
    chk("rst_a_busy", {31'd0, a_busy[0]}, 32'd1);
    chk("rst_b_busy", {31'd0, b_busy[0]}, 32'd1);
    chk("rst_a_rdy", {31'd0, a_rdy[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // A write then A read on the round-robin instance; B stays quiet
    watch_b = 1'b1;
    run_one(0, 0, 4'hf, 32'd4, 32'h1234_5678, rdy, dout, lat);
    $display("t2 A write 4: lat=%0d rdy=%0b", lat, rdy);
    chk("t2_wr_lat", lat, 32'd2);
    chk("t2_wr_rdy", {31'd0, rdy}, 32'd0);
    run_one(0, 0, 4'h0, 32'd4, 32'd0, rdy, dout, lat);
    $display("t2 A read 4: lat=%0d rdy=%0b data=%h", lat, rdy, dout);
    chk("t2_rd_lat", lat, 32'd3);
    chk("t2_rd_rdy", {31'd0, rdy}, 32'd1);
    chk("t2_rd_data", dout, 32'h1234_5678);
    @(posedge clk); #1;
    watch_b = 1'b0;
    chk("t2_b_quiet", b_viol, 32'd0);

    // Simultaneous requests right after reset: A first, then B after a bubble
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_two(0, 0, 4'h0, 32'd4, 32'd0, 4'hf, 32'd8, 32'habcd_ef01, cyc_a, cyc_b, dout);
    $display("t3 A read 4 / B write 8: a_done=%0d b_done=%0d a_data=%h", cyc_a, cyc_b, dout);
    chk("t3_a_cycle", cyc_a, 32'd3);
    chk("t3_b_cycle", cyc_b, 32'd5);
    chk("t3_a_data", dout, 32'h1234_5678);
    run_one(0, 1, 4'h0, 32'd8, 32'd0, rdy, dout, lat);
    $display("t3 B read 8: lat=%0d rdy=%0b data=%h", lat, rdy, dout);
    chk("t3_b_rd_data", dout, 32'habcd_ef01);
    chk("t3_b_rd_rdy", {31'd0, rdy}, 32'd1);

    // B write miss to 70, A read 4 one cycle later waits out the miss
    run_two(0, 1, 4'h0, 32'd4, 32'd0, 4'hf, 32'd70, 32'habcd_ef01, cyc_a, cyc_b, dout);
    $display("t4 B write 70 / A read 4: b_done=%0d a_done=%0d a_data=%h", cyc_b, cyc_a, dout);
    chk("t4_b_cycle", cyc_b, 32'd7);
    chk("t4_a_cycle", cyc_a, 32'd10);
    chk("t4_a_data", dout, 32'h1234_5678);

    // Owner drops enable mid-miss; the read still completes with its pulse
    set_req(0, 0, 1'b1, 4'h0, 32'd70, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 0, 1'b0, 4'h0, 32'd0, 32'd0);
    got = 1'b0;
    dout = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (a_rdy[0]) begin got = 1'b1; dout = a_dout[0]; end
    end
    $display("t4b A read 70 with enable dropped: pulse=%0b data=%h", got, dout);
    chk("t4b_pulse", {31'd0, got}, 32'd1);
    chk("t4b_data", dout, 32'habcd_ef01);
    @(posedge clk); #1;

    // Fixed priority, starve limit 2, both ports request continuously
    log_q.delete();
    set_req(1, 0, 1'b1, 4'hf, 32'd4, 32'h0000_00aa);
    set_req(1, 1, 1'b1, 4'hf, 32'd8, 32'h0000_00bb);
    for (int c = 0; c < 60 && log_q.size() < 6; c++) @(negedge clk);
    @(posedge clk); #1;
    set_req(1, 0, 1'b0, 4'h0, 32'd0, 32'd0);
    set_req(1, 1, 1'b0, 4'h0, 32'd0, 32'd0);
    chk("t5_count", (log_q.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
    exp_order = 6'b100100;
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      $display("t5 grant %0d: inst=%0d port=%s", i, log_q[i].inst, log_q[i].port ? "B" : "A");
      chk($sformatf("t5_grant%0d", i), {30'd0, log_q[i].inst, log_q[i].port},
          {30'd0, 1'b1, exp_order[i]});
    end

    // Reset during the WAIT of an A read miss
    set_req(0, 0, 1'b1, 4'h0, 32'd70, 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_in_wait_enable", {31'd0, c_en[0]}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    $display("t6 reset in WAIT: cache_enable=%0b a_busy=%0b b_busy=%0b", c_en[0], a_busy[0], b_busy[0]);
    chk("t6_rst_enable", {31'd0, c_en[0]}, 32'd0);
    chk("t6_rst_a_busy", {31'd0, a_busy[0]}, 32'd1);
    chk("t6_rst_b_busy", {31'd0, b_busy[0]}, 32'd1);
    set_req(0, 0, 1'b0, 4'h0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_one(0, 0, 4'h0, 32'd4, 32'd0, rdy, dout, lat);
    $display("t6 A read 4 after reset: lat=%0d rdy=%0b data=%h", lat, rdy, dout);
    chk("t6_rd_lat", lat, 32'd3);
    chk("t6_rd_data", dout, 32'h1234_5678);

    // No port ever reported data-ready while still busy
    chk("stray_ready_rr", g_inst[0].stray_cnt, 32'd0);
    chk("stray_ready_fixed", g_inst[1].stray_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
